// File: rtl/av_udp_tx_queue.sv
// av_udp_tx_queue: Avalon-MM channel register file plus send-request FIFO that hands packets to a UDP transmitter; optional irq port under macro UDP_TX_IRQ_EN
module av_udp_tx_queue #(
    parameter int NUM_CH = 4,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  address,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_req,
    input  logic        tx_ack,
    input  logic        tx_done,
    output logic [15:0] length_o,
    output logic [15:0] checksum_o,
    output logic [15:0] local_port_o,
    output logic [15:0] remote_port_o,
    output logic [31:0] remote_IP_o,
    output logic [31:0] remote_MAC_LSB_o,
    output logic [15:0] remote_MAC_MSB_o,
    output logic        busy_o,
    output logic [3:0]  level_o
`ifdef UDP_TX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int CS = 1 << CW;
    localparam int PW = $clog2(QDEPTH);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;
    logic [15:0] ch_len [CS];
    logic [15:0] ch_csum [CS];
    logic [15:0] ch_lport [CS];
    logic [15:0] ch_rport [CS];
    logic [31:0] ch_ip [CS];
    logic [31:0] ch_mac_lsb [CS];
    logic [15:0] ch_mac_msb [CS];
    logic [CW-1:0] fifo [QDEPTH];
    logic [PW-1:0] wp, rp;
    logic [3:0] cnt, wch;
    logic [CW-1:0] ci, hd;
    logic ovf, bad_ch, done;
    logic ch_hit, ctrl_wr, stat_wr, ch_ok, full, pop, push, set_ovf, set_bad, set_done;
    logic [31:0] status, ch_rd, rd_val;

    assign wch = address[6:3] - 4'd1;
    assign ci = wch[CW-1:0];
    assign ch_hit = address[6:3] != 4'd0 && int'(wch) < NUM_CH;
    assign ctrl_wr = write && address == 7'h00;
    assign stat_wr = write && address == 7'h01;
    assign ch_ok = int'(writedata[3:0]) < NUM_CH;
    assign full = cnt == 4'(QDEPTH);
    assign pop = state == IDLE && cnt != 4'd0;
    assign push = ctrl_wr && ch_ok && (!full || pop);
    assign set_ovf = ctrl_wr && ch_ok && full && !pop;
    assign set_bad = ctrl_wr && !ch_ok;
    assign set_done = (state == REQ && tx_ack && tx_done) || (state == WAIT && tx_done);
    assign hd = fifo[rp];
    assign level_o = cnt;
    assign status = {21'd0, done, bad_ch, ovf, cnt, 3'd0, busy_o};

    // channel register read mux; k = 7 is a hole in each channel window
    always_comb begin
        ch_rd = '0;
        case (address[2:0])
            3'd0: ch_rd = {16'd0, ch_len[ci]};
            3'd1: ch_rd = {16'd0, ch_csum[ci]};
            3'd2: ch_rd = {16'd0, ch_lport[ci]};
            3'd3: ch_rd = {16'd0, ch_rport[ci]};
            3'd4: ch_rd = ch_ip[ci];
            3'd5: ch_rd = ch_mac_lsb[ci];
            3'd6: ch_rd = {16'd0, ch_mac_msb[ci]};
            default: ch_rd = '0;
        endcase
    end

`ifdef UDP_TX_IRQ_EN
    logic irq_en;
    assign rd_val = address == 7'h01 ? status : address == 7'h02 ? {31'd0, irq_en} : ch_hit ? ch_rd : '0;
    assign irq = done & irq_en;
    // interrupt enable register
    always_ff @(posedge clk)
        if (reset) irq_en <= 1'b0;
        else if (write && address == 7'h02) irq_en <= writedata[0];
`else
    assign rd_val = address == 7'h01 ? status : ch_hit ? ch_rd : '0;
`endif

    // per-channel parameter registers
    always_ff @(posedge clk)
        if (reset) begin
            for (int i = 0; i < CS; i++) begin
                ch_len[i] <= 16'h0000;
                ch_csum[i] <= 16'h0BFF;
                ch_lport[i] <= 16'hAAAA;
                ch_rport[i] <= 16'hFDE2;
                ch_ip[i] <= 32'hAC1B01EB;
                ch_mac_lsb[i] <= 32'hD93049D0;
                ch_mac_msb[i] <= 16'hD4BD;
            end
        end else if (write && ch_hit) begin
            case (address[2:0])
                3'd0: ch_len[ci] <= writedata[15:0];
                3'd1: ch_csum[ci] <= writedata[15:0];
                3'd2: ch_lport[ci] <= writedata[15:0];
                3'd3: ch_rport[ci] <= writedata[15:0];
                3'd4: ch_ip[ci] <= writedata;
                3'd5: ch_mac_lsb[ci] <= writedata;
                3'd6: ch_mac_msb[ci] <= writedata[15:0];
                default: ;
            endcase
        end

    // send-request FIFO; pointers wrap naturally because QDEPTH is a power of two
    always_ff @(posedge clk)
        if (reset) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) fifo[wp] <= writedata[CW-1:0];
            wp <= wp + PW'(push);
            rp <= rp + PW'(pop);
            cnt <= cnt + {3'd0, push} - {3'd0, pop};
        end

    // sticky status flags: a set event in the same cycle beats a write-1-to-clear
    always_ff @(posedge clk)
        if (reset) begin
            ovf <= 1'b0;
            bad_ch <= 1'b0;
            done <= 1'b0;
        end else begin
            ovf <= set_ovf | (ovf & ~(stat_wr & writedata[8]));
            bad_ch <= set_bad | (bad_ch & ~(stat_wr & writedata[9]));
            done <= set_done | (done & ~(stat_wr & writedata[10]));
        end

    // registered read data with one cycle of latency
    always_ff @(posedge clk)
        if (reset) readdata <= '0;
        else readdata <= read ? rd_val : '0;

    // transmit handshake FSM; the snapshot is taken on the pop and held until the next pop
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            tx_req <= 1'b0;
            busy_o <= 1'b0;
            length_o <= 16'h0000;
            checksum_o <= 16'h0BFF;
            local_port_o <= 16'hAAAA;
            remote_port_o <= 16'hFDE2;
            remote_IP_o <= 32'hAC1B01EB;
            remote_MAC_LSB_o <= 32'hD93049D0;
            remote_MAC_MSB_o <= 16'hD4BD;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    state <= REQ;
                    tx_req <= 1'b1;
                    busy_o <= 1'b1;
                    length_o <= ch_len[hd];
                    checksum_o <= ch_csum[hd];
                    local_port_o <= ch_lport[hd];
                    remote_port_o <= ch_rport[hd];
                    remote_IP_o <= ch_ip[hd];
                    remote_MAC_LSB_o <= ch_mac_lsb[hd];
                    remote_MAC_MSB_o <= ch_mac_msb[hd];
                end
                REQ: if (tx_ack) begin
                    state <= tx_done ? IDLE : WAIT;
                    tx_req <= 1'b0;
                    busy_o <= !tx_done;
                end
                WAIT: if (tx_done) begin
                    state <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_av_udp_tx_queue.sv
// tb_av_udp_tx_queue: directed and randomized checks of av_udp_tx_queue against a queue-based behavioural model
module tb_av_udp_tx_queue;
    localparam int NUM_CH = 4;
    localparam int QDEPTH = 4;
    localparam logic [31:0] RV [7] = '{32'h0, 32'h0BFF, 32'hAAAA, 32'hFDE2, 32'hAC1B01EB, 32'hD93049D0, 32'hD4BD};

    logic clk = 0, reset = 1, write = 0, read = 0, tx_ack = 0, tx_done = 0;
    logic [6:0] address = 0;
    logic [31:0] writedata = 0, readdata, remote_IP_o, remote_MAC_LSB_o;
    logic [15:0] length_o, checksum_o, local_port_o, remote_port_o, remote_MAC_MSB_o;
    logic tx_req, busy_o;
    logic [3:0] level_o;
`ifdef UDP_TX_IRQ_EN
    logic irq;
`endif

    av_udp_tx_queue #(.NUM_CH(NUM_CH), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
        .writedata(writedata), .readdata(readdata), .tx_req(tx_req), .tx_ack(tx_ack),
        .tx_done(tx_done), .length_o(length_o), .checksum_o(checksum_o),
        .local_port_o(local_port_o), .remote_port_o(remote_port_o), .remote_IP_o(remote_IP_o),
        .remote_MAC_LSB_o(remote_MAC_LSB_o), .remote_MAC_MSB_o(remote_MAC_MSB_o),
        .busy_o(busy_o), .level_o(level_o)
`ifdef UDP_TX_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit chk_en = 0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    // behavioural model: phase 0 idle, 1 requesting, 2 waiting for done
    logic [31:0] m_reg [NUM_CH][7];
    logic [31:0] m_snap [7];
    int q[$];
    int m_phase, m_c, m_k, m_ch;
    bit m_ovf, m_bad, m_done, m_irq_en, m_pop, m_push, s_ovf, s_bad, s_done;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_status();
        return {21'd0, m_done, m_bad, m_ovf, 4'(q.size()), 3'd0, m_phase != 0};
    endfunction

    function automatic logic [31:0] m_read(logic [6:0] a);
        int c = int'(a[6:3]) - 1;
        int k = int'(a[2:0]);
        if (a == 7'h01) return m_status();
`ifdef UDP_TX_IRQ_EN
        if (a == 7'h02) return {31'd0, m_irq_en};
`endif
        if (c >= 0 && c < NUM_CH && k < 7) return m_reg[c][k];
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < 7; k++) m_reg[c][k] = RV[k];
            for (int k = 0; k < 7; k++) m_snap[k] = RV[k];
            q.delete();
            m_phase = 0; m_ovf = 0; m_bad = 0; m_done = 0; m_irq_en = 0; m_rd = 0;
        end else begin
            m_rd = read ? m_read(address) : 0;
            m_pop = m_phase == 0 && q.size() > 0;
            s_done = (m_phase == 1 && tx_ack && tx_done) || (m_phase == 2 && tx_done);
            s_ovf = 0; s_bad = 0; m_push = 0;
            m_ch = int'(writedata[3:0]);
            if (write && address == 0) begin
                if (m_ch >= NUM_CH) s_bad = 1;
                else if (q.size() == QDEPTH && !m_pop) s_ovf = 1;
                else m_push = 1;
            end
            if (write && address == 1) begin
                if (writedata[8]) m_ovf = 0;
                if (writedata[9]) m_bad = 0;
                if (writedata[10]) m_done = 0;
            end
            m_ovf |= s_ovf; m_bad |= s_bad; m_done |= s_done;
`ifdef UDP_TX_IRQ_EN
            if (write && address == 2) m_irq_en = writedata[0];
`endif
            if (m_pop) begin
                m_c = q.pop_front();
                for (int k = 0; k < 7; k++) m_snap[k] = m_reg[m_c][k];
                m_phase = 1;
            end else if (m_phase == 1 && tx_ack) m_phase = tx_done ? 0 : 2;
            else if (m_phase == 2 && tx_done) m_phase = 0;
            if (m_push) q.push_back(m_ch);
            m_c = int'(address[6:3]) - 1;
            m_k = int'(address[2:0]);
            if (write && m_c >= 0 && m_c < NUM_CH && m_k < 7)
                m_reg[m_c][m_k] = (m_k == 4 || m_k == 5) ? writedata : {16'd0, writedata[15:0]};
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) if (chk_en) begin
        chk("tx_req", tx_req, m_phase == 1);
        chk("busy_o", busy_o, m_phase != 0);
        chk("level_o", level_o, q.size());
        chk("length_o", length_o, m_snap[0]);
        chk("checksum_o", checksum_o, m_snap[1]);
        chk("local_port_o", local_port_o, m_snap[2]);
        chk("remote_port_o", remote_port_o, m_snap[3]);
        chk("remote_IP_o", remote_IP_o, m_snap[4]);
        chk("remote_MAC_LSB_o", remote_MAC_LSB_o, m_snap[5]);
        chk("remote_MAC_MSB_o", remote_MAC_MSB_o, m_snap[6]);
        chk("readdata", readdata, m_rd);
`ifdef UDP_TX_IRQ_EN
        chk("irq", irq, m_done & m_irq_en);
`endif
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [6:0] a, logic [31:0] d);
        address = a; writedata = d; write = 1; read = 0;
        tick(1);
        write = 0;
    endtask

    task automatic rd(logic [6:0] a, output logic [31:0] d);
        address = a; read = 1; write = 0;
        tick(1);
        read = 0;
        d = readdata;
    endtask

    initial begin
        logic [31:0] d;
        int r;
        tick(1);
        chk_en = 1;
        tick(2);
        reset = 0;
        chk("rst_tx_req", tx_req, 0);
        chk("rst_level", level_o, 0);
        chk("rst_ip_o", remote_IP_o, 32'hAC1B01EB);
        rd(7'h0C, d); chk("rd_ch0_ip", d, 32'hAC1B01EB);
        rd(7'h01, d); chk("rd_status_rst", d, 0);
        // doorbell latency and full handshake
        wr(7'h13, 32'h1234);
        wr(7'h00, 1);
        chk("lat_tx_req_n", tx_req, 0);
        tick(1);
        chk("lat_tx_req_n1", tx_req, 1);
        chk("lat_rport", remote_port_o, 16'h1234);
        tx_ack = 1; tick(1); tx_ack = 0;
        chk("wait_busy", busy_o, 1);
        chk("wait_req", tx_req, 0);
        tx_done = 1; tick(1); tx_done = 0;
        chk("done_busy", busy_o, 0);
        rd(7'h01, d); chk("done_status", d, 32'h400);
        wr(7'h01, 32'h400);
        // overflow with the transmitter stalled in REQ
        wr(7'h00, 0); tick(1);
        for (int i = 0; i < 5; i++) wr(7'h00, 0);
        chk("ovf_level", level_o, 4);
        rd(7'h01, d); chk("ovf_status", d, 32'h141);
        wr(7'h01, 32'h100);
        rd(7'h01, d); chk("ovf_clear", d, 32'h041);
        wr(7'h00, 9);
        chk("bad_level", level_o, 4);
        rd(7'h01, d); chk("bad_status", d, 32'h241);
        wr(7'h01, 32'h200);
        // full FIFO: push and pop on the same edge both succeed
        tx_ack = 1; tx_done = 1; tick(1); tx_ack = 0; tx_done = 0;
        wr(7'h00, 2);
        chk("full_pp_level", level_o, 4);
        chk("full_pp_req", tx_req, 1);
        rd(7'h01, d); chk("full_pp_status", d, 32'h441);
        wr(7'h01, 32'h400);
        tx_ack = 1; tx_done = 1;
        for (int i = 0; i < 40 && (level_o != 0 || busy_o); i++) tick(1);
        tx_ack = 0; tx_done = 0;
        chk("drain_level", level_o, 0);
        chk("drain_busy", busy_o, 0);
        wr(7'h01, 32'h400);
        // snapshot held while busy
        wr(7'h08, 32'h55);
        wr(7'h00, 0); tick(1);
        chk("snap_len", length_o, 16'h55);
        tx_ack = 1; tick(1); tx_ack = 0;
        wr(7'h08, 32'h66);
        tick(2);
        chk("snap_hold", length_o, 16'h55);
        tx_done = 1; tick(1); tx_done = 0;
        chk("snap_idle", length_o, 16'h55);
        wr(7'h00, 0); tick(1);
        chk("snap_new", length_o, 16'h66);
        // reset in the middle of a packet
        tx_ack = 1; tick(1); tx_ack = 0;
        reset = 1; tick(1); reset = 0;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_len", length_o, 0);
        rd(7'h01, d); chk("mid_rst_status", d, 0);
        rd(7'h08, d); chk("mid_rst_ch0_len", d, 0);
`ifdef UDP_TX_IRQ_EN
        wr(7'h02, 1);
        rd(7'h02, d); chk("irq_en_rd", d, 1);
        wr(7'h00, 0); tick(1);
        tx_ack = 1; tx_done = 1; tick(1); tx_ack = 0; tx_done = 0;
        chk("irq_set", irq, 1);
        wr(7'h01, 32'h400);
        chk("irq_clr", irq, 0);
`else
        wr(7'h02, 1);
        rd(7'h02, d); chk("irq_en_absent", d, 0);
`endif
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            write = 0; read = 0;
            writedata = $urandom();
            if (r < 15) begin
                address = 0; write = 1;
                writedata[3:0] = 4'($urandom_range(0, NUM_CH + 1));
            end else if (r < 30) begin
                address = {4'($urandom_range(1, NUM_CH + 1)), 3'($urandom_range(0, 7))}; write = 1;
            end else if (r < 36) begin
                address = 1; write = 1;
            end else if (r < 40) begin
                address = 2; write = 1;
            end else if (r < 65) begin
                address = 7'($urandom_range(0, 8 * (NUM_CH + 2))); read = 1;
            end
            tx_ack = $urandom_range(0, 3) == 0;
            tx_done = $urandom_range(0, 3) == 0 && !(m_phase == 1 && !tx_ack);
            reset = $urandom_range(0, 499) == 0;
            tick(1);
        end
        write = 0; read = 0; tx_ack = 0; tx_done = 0; reset = 0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/av_udp_tx_queue.md
AV_UDP_TX_QUEUE -- requirements
Module: av_udp_tx_queue

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of destination channels (1..8).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning the send-request FIFO depth (power of 2, 2..8).
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports address in 7, write in 1, read in 1, writedata in 32, readdata out 32, forming the Avalon-MM slave.
REQ-006 SHALL have ports tx_req out 1, tx_ack in 1, tx_done in 1, forming the handshake to the UDP transmitter.
REQ-007 SHALL have ports length_o out 16, checksum_o out 16, local_port_o out 16, remote_port_o out 16, remote_IP_o out 32, remote_MAC_LSB_o out 32, remote_MAC_MSB_o out 16, carrying the snapshot of the active packet's parameters.
REQ-008 SHALL have ports busy_o out 1 (FSM not IDLE) and level_o out 4 (FIFO occupancy).

Function
REQ-009 SHALL decode global registers at 0x00 CTRL (write-only doorbell), 0x01 STATUS, and 0x02 IRQ_EN.
REQ-010 SHALL place channel c registers at 0x08*(c+1)+k, with k = 0 length, 1 checksum, 2 local_port, 3 remote_port, 4 IP, 5 MAC_LSB, 6 MAC_MSB; 16-bit fields SHALL use writedata[15:0].
REQ-011 SHALL register readdata with 1-cycle read latency; unmapped, write-only or out-of-range addresses SHALL read 0.
REQ-012 SHALL treat a CTRL write as a push of channel index writedata[3:0] into the FIFO.
REQ-013 SHALL, for an index >= NUM_CH, drop the push and set sticky STATUS[9] bad_ch.
REQ-014 SHALL, when the FIFO is full with no pop in the same cycle, drop the push and set sticky STATUS[8] ovf; push and pop in the same cycle when full SHALL both succeed.
REQ-015 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop one entry, snapshot that channel's registers into the *_o outputs, and enter REQ on the same edge.
REQ-017 SHALL assert tx_req only in REQ; tx_ack in REQ SHALL lead to WAIT, and tx_ack with tx_done in the same cycle SHALL lead to IDLE.
REQ-018 SHALL go from WAIT to IDLE on tx_done; tx_done outside REQ/WAIT SHALL be ignored.
REQ-019 SHALL give a doorbell to tx_req latency of 2 cycles when idle and the FIFO is empty (push at edge N, pop at N+1, tx_req high after N+1).
REQ-020 SHALL hold the snapshot unchanged while busy; channel register writes SHALL affect only later packets.
REQ-021 SHALL return in STATUS: [0] busy, [7:4] level, [8] ovf, [9] bad_ch, [10] done; writing 1 to bits 8..10 SHALL clear them, and a same-cycle set event SHALL win over the clear.
REQ-022 SHALL set STATUS[10] done on every WAIT/REQ -> IDLE transition caused by tx_done.

Reset
REQ-023 SHALL, on reset, set every channel to length 0x0000, checksum 0x0BFF, local_port 0xAAAA, remote_port 0xFDE2, IP 0xAC1B01EB, MAC_LSB 0xD93049D0, MAC_MSB 0xD4BD.
REQ-024 SHALL, on reset, empty the FIFO, put the FSM in IDLE, clear STATUS sticky bits and IRQ_EN, and set tx_req, readdata, busy_o and level_o to 0.
REQ-025 SHALL, on reset asserted mid-transaction, abandon the packet with no done flag; the snapshot outputs SHALL take channel-0 reset values.

Configuration
REQ-026 SHALL, when macro UDP_TX_IRQ_EN is defined, add port irq (out, 1) = STATUS[10] AND IRQ_EN[0], with IRQ_EN read/write at 0x02.
REQ-027 SHALL, when UDP_TX_IRQ_EN is undefined, omit the irq port, ignore writes to 0x02, and read 0x02 as 0.

Verification
REQ-028 SHALL verify: after reset, read 0x0C (ch0 IP) -> 0xAC1B01EB one cycle later; read 0x01 -> 0.
REQ-029 SHALL verify: write 0x10+3 = 0x1234, write CTRL = 1 -> tx_req rises 2 cycles later with remote_port_o = 0x1234; tx_ack then tx_done -> busy_o = 0 and STATUS = 0x400.
REQ-030 SHALL verify: with tx_ack held low, write CTRL 5 times (QDEPTH 4) -> level_o = 4, STATUS[8] = 1; write 0x100 to STATUS -> bit8 clears.
REQ-031 SHALL verify: write CTRL = 9 with NUM_CH 4 -> level unchanged, STATUS[9] = 1.
REQ-032 SHALL verify: while in WAIT, write the ch0 length register -> length_o unchanged until the next pop.
REQ-033 SHALL verify: with UDP_TX_IRQ_EN, IRQ_EN = 1 and a packet completed -> irq = 1; W1C done -> irq = 0 next cycle.
